// File: rtl/text_console_if.sv
// Byte-stream input and character-buffer write port of the text console controller.
interface text_console_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wen;
  logic [10:0] write_addr;
  logic [7:0]  write_data;

  modport master (
    output in_valid, in_data,
    input  in_ready, wen, write_addr, write_data
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, wen, write_addr, write_data
  );
endinterface

// File: rtl/text_console_ctrl.sv
// Text console sequencer: byte stream in, one-cell writes out, hardware scroll via top_row.
// Optional macro TEXT_CONSOLE_AUTOWRAP_EN enables wrap to the next line at the right edge.
module text_console_ctrl #(
  parameter int unsigned COLS  = 80,
  parameter int unsigned ROWS  = 25,
  parameter int unsigned TAB_W = 8
) (
  input  logic           clk,
  input  logic           reset,
  text_console_if.slave  bus,
  output logic [6:0]     cursor_col,
  output logic [4:0]     cursor_row,
  output logic [4:0]     top_row,
  output logic           busy
);
  localparam int unsigned COL_W  = 7;
  localparam int unsigned ROW_W  = 5;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned CNT_W  = 12;
  localparam int unsigned CELLS  = COLS * ROWS;

  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_TAB = 8'h09;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_FF  = 8'h0C;
  localparam logic [7:0] CH_CR  = 8'h0D;

  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);

  typedef enum logic [1:0] {
    ST_CLR_ALL,
    ST_IDLE,
    ST_EXEC,
    ST_CLR_LINE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                wen_q, wen_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          data_q, data_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [ROW_W-1:0]    top_q, top_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic                pend_scroll_q, pend_scroll_d;
  logic                pend_ff_q, pend_ff_d;
  logic [ADDR_W-1:0]   clr_base_q, clr_base_d;

  // Decode of the byte on offer, evaluated against the current cursor
  logic [COL_W:0]      tab_col;
  logic [ROW_W:0]      phys_sum;
  logic [ROW_W-1:0]    phys_row;
  logic [ADDR_W-1:0]   row_base;
  logic [ADDR_W-1:0]   wr_addr;
  logic [COL_W-1:0]    wr_col;
  logic [COL_W-1:0]    nx_col;
  logic [ROW_W-1:0]    nx_row;
  logic [ROW_W-1:0]    nx_top;
  logic [7:0]          nx_data;
  logic                nx_wr;
  logic                nx_scroll;
  logic                nx_ff;
  logic                line_end;

  always_comb begin
    phys_sum  = {1'b0, top_q} + {1'b0, row_q};
    phys_row  = (phys_sum >= (ROW_W+1)'(ROWS)) ? ROW_W'(phys_sum - (ROW_W+1)'(ROWS))
                                               : phys_sum[ROW_W-1:0];
    row_base  = ADDR_W'(phys_row) * COLS_A;
    tab_col   = ({1'b0, col_q} | (COL_W+1)'(TAB_W - 1)) + (COL_W+1)'(1);

    nx_col    = col_q;
    nx_row    = row_q;
    nx_top    = top_q;
    nx_data   = bus.in_data;
    nx_wr     = 1'b0;
    nx_scroll = 1'b0;
    nx_ff     = 1'b0;
    wr_col    = col_q;
    line_end  = 1'b0;

    case (bus.in_data)
      CH_LF: line_end = 1'b1;
      CH_CR: nx_col = '0;
      CH_BS: begin
        if (col_q != '0) begin
          nx_col  = col_q - COL_W'(1);
          wr_col  = col_q - COL_W'(1);
          nx_wr   = 1'b1;
          nx_data = 8'h00;
        end
      end
      CH_TAB: begin
        if (tab_col < (COL_W+1)'(COLS)) nx_col = tab_col[COL_W-1:0];
`ifdef TEXT_CONSOLE_AUTOWRAP_EN
        else line_end = 1'b1;
`else
        else nx_col = LAST_COL;
`endif
      end
      CH_FF: begin
        nx_ff  = 1'b1;
        nx_col = '0;
        nx_row = '0;
        nx_top = '0;
      end
      default: begin
        nx_wr = 1'b1;
        if (col_q != LAST_COL) nx_col = col_q + COL_W'(1);
`ifdef TEXT_CONSOLE_AUTOWRAP_EN
        else line_end = 1'b1;
`endif
      end
    endcase

    // Line end: carriage return plus line feed, scrolling at the bottom row
    if (line_end) begin
      nx_col = '0;
      if (row_q != LAST_ROW) begin
        nx_row = row_q + ROW_W'(1);
      end else begin
        nx_scroll = 1'b1;
        nx_top    = (top_q == LAST_ROW) ? '0 : top_q + ROW_W'(1);
      end
    end

    wr_addr = row_base + ADDR_W'(wr_col);
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wen_d         = 1'b0;
    addr_d        = addr_q;
    data_d        = data_q;
    col_d         = col_q;
    row_d         = row_q;
    top_d         = top_q;
    in_ready_d    = in_ready_q;
    pend_scroll_d = pend_scroll_q;
    pend_ff_d     = pend_ff_q;
    clr_base_d    = clr_base_q;

    case (state_q)
      ST_CLR_ALL: begin
        if (cnt_q < CNT_W'(CELLS)) begin
          wen_d  = 1'b1;
          addr_d = ADDR_W'(cnt_q);
          data_d = 8'h00;
          cnt_d  = cnt_q + CNT_W'(1);
        end else begin
          state_d    = ST_IDLE;
          in_ready_d = 1'b1;
        end
      end
      ST_IDLE: begin
        in_ready_d = 1'b1;
        if (bus.in_valid && in_ready_q) begin
          state_d       = ST_EXEC;
          in_ready_d    = 1'b0;
          wen_d         = nx_wr;
          if (nx_wr) begin
            addr_d = wr_addr;
            data_d = nx_data;
          end
          col_d         = nx_col;
          row_d         = nx_row;
          top_d         = nx_top;
          pend_scroll_d = nx_scroll;
          pend_ff_d     = nx_ff;
          clr_base_d    = ADDR_W'(top_q) * COLS_A;
        end
      end
      ST_EXEC: begin
        if (pend_ff_q) begin
          state_d = ST_CLR_ALL;
          cnt_d   = '0;
        end else if (pend_scroll_q) begin
          // The first cell of the freed row goes out right away
          state_d = ST_CLR_LINE;
          wen_d   = 1'b1;
          addr_d  = clr_base_q;
          data_d  = 8'h00;
          cnt_d   = CNT_W'(1);
        end else begin
          state_d    = ST_IDLE;
          in_ready_d = 1'b1;
        end
      end
      ST_CLR_LINE: begin
        if (cnt_q < CNT_W'(COLS)) begin
          wen_d  = 1'b1;
          addr_d = clr_base_q + ADDR_W'(cnt_q);
          data_d = 8'h00;
          cnt_d  = cnt_q + CNT_W'(1);
        end else begin
          state_d    = ST_IDLE;
          in_ready_d = 1'b1;
        end
      end
      default: state_d = ST_CLR_ALL;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_CLR_ALL;
      cnt_q         <= '0;
      wen_q         <= 1'b0;
      addr_q        <= '0;
      data_q        <= '0;
      col_q         <= '0;
      row_q         <= '0;
      top_q         <= '0;
      in_ready_q    <= 1'b0;
      busy_q        <= 1'b1;
      pend_scroll_q <= 1'b0;
      pend_ff_q     <= 1'b0;
      clr_base_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wen_q         <= wen_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      col_q         <= col_d;
      row_q         <= row_d;
      top_q         <= top_d;
      in_ready_q    <= in_ready_d;
      busy_q        <= busy_d;
      pend_scroll_q <= pend_scroll_d;
      pend_ff_q     <= pend_ff_d;
      clr_base_q    <= clr_base_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.wen        = wen_q;
  assign bus.write_addr = addr_q;
  assign bus.write_data = data_q;
  assign cursor_col     = col_q;
  assign cursor_row     = row_q;
  assign top_row        = top_q;
  assign busy           = busy_q;
endmodule

// File: tb/tb_text_console_ctrl.sv
// Bench for text_console_ctrl: directed timing checks plus random streams against a logical-screen model.
module tb_text_console_ctrl;
  localparam int COLS  = 80;
  localparam int ROWS  = 25;
  localparam int TAB_W = 8;
  localparam int CELLS = COLS * ROWS;
  localparam int LIMIT = 5000;
`ifdef TEXT_CONSOLE_AUTOWRAP_EN
  localparam bit AUTOWRAP = 1'b1;
`else
  localparam bit AUTOWRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;
  logic [4:0] top_row;
  logic       busy;

  text_console_if bus ();

  text_console_ctrl #(.COLS(COLS), .ROWS(ROWS), .TAB_W(TAB_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .top_row    (top_row),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Image of the physical buffer as seen through the write port
  logic [7:0] img [CELLS] = '{default: 8'hFF};
  int         wa [$];
  logic [7:0] wd [$];

  always @(negedge clk) begin
    if (bus.wen === 1'b1) begin
      if (int'(bus.write_addr) < CELLS) img[bus.write_addr] = bus.write_data;
      wa.push_back(int'(bus.write_addr));
      wd.push_back(bus.write_data);
    end
  end

  // Reference: logical screen that physically shifts its rows on scroll
  logic [7:0] scr [ROWS][COLS];
  int m_col = 0, m_row = 0, m_top = 0;

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) scr[r][c] = 8'h00;
    m_col = 0; m_row = 0; m_top = 0;
  endtask

  task automatic model_newline();
    m_col = 0;
    if (m_row < ROWS - 1) m_row++;
    else begin
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
      for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = 8'h00;
      m_top = (m_top + 1) % ROWS;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    int t;
    case (b)
      8'h0A: model_newline();
      8'h0D: m_col = 0;
      8'h08: if (m_col > 0) begin m_col--; scr[m_row][m_col] = 8'h00; end
      8'h09: begin
        t = (m_col / TAB_W + 1) * TAB_W;
        if (t < COLS) m_col = t;
        else if (AUTOWRAP) model_newline();
        else m_col = COLS - 1;
      end
      8'h0C: model_clear();
      default: begin
        scr[m_row][m_col] = b;
        if (m_col < COLS - 1) m_col++;
        else if (AUTOWRAP) model_newline();
      end
    endcase
  endtask

  function automatic int screen_diffs();
    int n = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (img[((int'(top_row) + r) % ROWS) * COLS + c] !== scr[r][c]) n++;
    return n;
  endfunction

  // Call at a negedge; returns at the negedge following acceptance
  task automatic send(input logic [7:0] b);
    int guard = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && guard < LIMIT) begin @(negedge clk); guard++; end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
    model_byte(b);
    tests_run++;
    if (guard >= LIMIT) begin
      tests_failed++;
      $display("FAIL send_accept: in_ready=%b after %0d cycles, want 1", bus.in_ready, guard);
    end
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (bus.in_ready !== 1'b1 && guard < LIMIT) begin @(negedge clk); guard++; end
    tests_run++;
    if (guard >= LIMIT) begin
      tests_failed++;
      $display("FAIL wait_idle: in_ready=%b after %0d cycles, want 1", bus.in_ready, guard);
    end
  endtask

  task automatic check_cursor(input string name, input int row, input int col, input int top);
    tests_run++;
    if (cursor_row !== 5'(row) || cursor_col !== 7'(col) || top_row !== 5'(top)) begin
      tests_failed++;
      $display("FAIL %s: got row=%0d col=%0d top=%0d, want row=%0d col=%0d top=%0d",
               name, cursor_row, cursor_col, top_row, row, col, top);
    end
  endtask

  task automatic test_reset();
    int idx = 0, cyc = 0, last_w = -10, rise = -1, bad = 0;
    reset = 1'b1; bus.in_valid = 1'b0; bus.in_data = 8'h00;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({bus.wen, bus.in_ready, busy, bus.write_addr, bus.write_data} !== {1'b0, 1'b0, 1'b1, 11'd0, 8'd0}) begin
      tests_failed++;
      $display("FAIL reset_outputs: got wen=%b rdy=%b busy=%b addr=%0d data=%h, want 0 0 1 0 00",
               bus.wen, bus.in_ready, busy, bus.write_addr, bus.write_data);
    end
    check_cursor("reset_cursor", 0, 0, 0);
    reset = 1'b0;
    while (rise < 0 && cyc < CELLS + 100) begin
      @(negedge clk); cyc++;
      if (bus.wen === 1'b1) begin
        if (int'(bus.write_addr) != idx || bus.write_data !== 8'h00 || bus.in_ready !== 1'b0) bad++;
        idx++; last_w = cyc;
      end else if (bus.in_ready === 1'b1) rise = cyc;
    end
    tests_run++;
    if (idx != CELLS || bad != 0) begin
      tests_failed++;
      $display("FAIL clr_all_writes: got %0d writes with %0d bad, want %0d with 0 bad", idx, bad, CELLS);
    end
    tests_run++;
    if (rise != last_w + 1) begin
      tests_failed++;
      $display("FAIL clr_all_ready: in_ready rose at cycle %0d, want %0d", rise, last_w + 1);
    end
    check_cursor("clr_all_cursor", 0, 0, 0);
    model_clear();
    tests_run++;
    if (screen_diffs() != 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL clr_all_screen: got %0d cell diffs busy=%b, want 0 diffs busy=0", screen_diffs(), busy);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 8'h48;
    @(negedge clk);
    tests_run++;
    if ({bus.wen, bus.write_addr, bus.write_data, bus.in_ready} !== {1'b1, 11'd0, 8'h48, 1'b0}) begin
      tests_failed++;
      $display("FAIL hi_write_h: got wen=%b addr=%0d data=%h rdy=%b, want 1 0 48 0",
               bus.wen, bus.write_addr, bus.write_data, bus.in_ready);
    end
    bus.in_data = 8'h69;
    @(negedge clk);
    tests_run++;
    if ({bus.wen, bus.in_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL hi_gap: got wen=%b rdy=%b, want wen=0 rdy=1", bus.wen, bus.in_ready);
    end
    @(negedge clk);
    tests_run++;
    if ({bus.wen, bus.write_addr, bus.write_data, bus.in_ready} !== {1'b1, 11'd1, 8'h69, 1'b0}) begin
      tests_failed++;
      $display("FAIL hi_write_i: got wen=%b addr=%0d data=%h rdy=%b, want 1 1 69 0",
               bus.wen, bus.write_addr, bus.write_data, bus.in_ready);
    end
    bus.in_valid = 1'b0;
    model_byte(8'h48); model_byte(8'h69);
    @(negedge clk);
    check_cursor("hi_cursor", 0, 2, 0);
  endtask

  task automatic test_bs_tab();
    int n;
    send(8'h0D); wait_idle();
    n = wa.size();
    send(8'h08); wait_idle();
    tests_run++;
    if (wa.size() != n || cursor_col !== 7'd0) begin
      tests_failed++;
      $display("FAIL bs_col0: got %0d writes col=%0d, want 0 writes col=0", wa.size() - n, cursor_col);
    end
    send(8'h61); send(8'h62); send(8'h63); send(8'h09); wait_idle();
    check_cursor("tab_col3", 0, 8, 0);
    send(8'h08); wait_idle();
    tests_run++;
    if (wa[wa.size()-1] != 7 || wd[wd.size()-1] !== 8'h00 || cursor_col !== 7'd7) begin
      tests_failed++;
      $display("FAIL bs_erase: got addr=%0d data=%h col=%0d, want addr=7 data=00 col=7",
               wa[wa.size()-1], wd[wd.size()-1], cursor_col);
    end
  endtask

  task automatic test_scroll_bottom();
    int bad = 0;
    send(8'h0C); wait_idle();
    repeat (ROWS - 1) send(8'h0A);
    repeat (5) send(8'h71);
    wait_idle();
    check_cursor("pre_scroll", 24, 5, 0);
    bus.in_valid = 1'b1; bus.in_data = 8'h0A;
    @(negedge clk);
    bus.in_valid = 1'b0;
    model_byte(8'h0A);
    check_cursor("scroll_exec", 24, 0, 1);
    tests_run++;
    if ({bus.wen, busy, bus.in_ready} !== 3'b010) begin
      tests_failed++;
      $display("FAIL scroll_exec_flags: got wen=%b busy=%b rdy=%b, want 0 1 0", bus.wen, busy, bus.in_ready);
    end
    for (int i = 0; i < COLS; i++) begin
      @(negedge clk);
      if (bus.wen !== 1'b1 || int'(bus.write_addr) != i || bus.write_data !== 8'h00 ||
          busy !== 1'b1 || bus.in_ready !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL clr_line_seq: got %0d bad cycles, want 0", bad);
    end
    @(negedge clk);
    tests_run++;
    if ({bus.wen, busy, bus.in_ready} !== 3'b001) begin
      tests_failed++;
      $display("FAIL clr_line_end: got wen=%b busy=%b rdy=%b, want 0 0 1", bus.wen, busy, bus.in_ready);
    end
  endtask

  task automatic test_top_wrap();
    int n, bad = 0;
    repeat (23) send(8'h0A);
    wait_idle();
    check_cursor("top_24", 24, 0, 24);
    n = wa.size();
    send(8'h0A); wait_idle();
    for (int i = 0; i < COLS; i++)
      if (n + i >= wa.size() || wa[n+i] != 1920 + i || wd[n+i] !== 8'h00) bad++;
    tests_run++;
    if (wa.size() - n != COLS || bad != 0 || top_row !== 5'd0) begin
      tests_failed++;
      $display("FAIL top_wrap_clear: got %0d writes %0d bad top=%0d, want 80 writes 0 bad top=0",
               wa.size() - n, bad, top_row);
    end
    send(8'h41); wait_idle();
    tests_run++;
    if (wa[wa.size()-1] != 1920 || wd[wd.size()-1] !== 8'h41) begin
      tests_failed++;
      $display("FAIL top_wrap_a: got addr=%0d data=%h, want addr=1920 data=41",
               wa[wa.size()-1], wd[wd.size()-1]);
    end
    check_cursor("top_wrap_cursor", 24, 1, 0);
  endtask

  task automatic test_autowrap();
    int sz;
    send(8'h0C); wait_idle();
    repeat (COLS - 1) send(8'h78);
    send(8'h79); send(8'h7A); wait_idle();
    sz = wa.size();
    tests_run++;
    if (wa[sz-2] != 79 || wd[sz-2] !== 8'h79 || wa[sz-1] != (AUTOWRAP ? 80 : 79) || wd[sz-1] !== 8'h7A) begin
      tests_failed++;
      $display("FAIL edge_writes: got y@%0d=%h z@%0d=%h, want y@79=79 z@%0d=7a",
               wa[sz-2], wd[sz-2], wa[sz-1], wd[sz-1], AUTOWRAP ? 80 : 79);
    end
    check_cursor("edge_cursor", AUTOWRAP ? 1 : 0, AUTOWRAP ? 1 : 79, 0);
  endtask

  task automatic test_random();
    logic [7:0] b;
    int r;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 12) b = 8'h0A;
      else if (r < 16) b = 8'h0D;
      else if (r < 22) b = 8'h08;
      else if (r < 29) b = 8'h09;
      else if (r < 30) b = 8'h0C;
      else begin
        b = 8'($urandom);
        if (b == 8'h0A || b == 8'h0D || b == 8'h08 || b == 8'h09 || b == 8'h0C) b = 8'h2A;
      end
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      send(b);
    end
    wait_idle();
    check_cursor("random_cursor", m_row, m_col, m_top);
    tests_run++;
    if (screen_diffs() != 0) begin
      tests_failed++;
      $display("FAIL random_screen: got %0d cell diffs, want 0", screen_diffs());
    end
  endtask

  task automatic test_reset_mid_clr_line();
    send(8'h0C);
    repeat (ROWS - 1) send(8'h0A);
    wait_idle();
    bus.in_valid = 1'b1; bus.in_data = 8'h0A;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    tests_run++;
    if (bus.wen !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_clr_active: got wen=%b busy=%b, want 1 1", bus.wen, busy);
    end
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({bus.wen, busy, bus.in_ready} !== 3'b010) begin
      tests_failed++;
      $display("FAIL mid_reset_abort: got wen=%b busy=%b rdy=%b, want 0 1 0", bus.wen, busy, bus.in_ready);
    end
    check_cursor("mid_reset_cursor", 0, 0, 0);
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({bus.wen, bus.write_addr, bus.write_data} !== {1'b1, 11'd0, 8'h00}) begin
      tests_failed++;
      $display("FAIL mid_reset_restart: got wen=%b addr=%0d data=%h, want 1 0 00",
               bus.wen, bus.write_addr, bus.write_data);
    end
    wait_idle();
    model_clear();
    tests_run++;
    if (screen_diffs() != 0) begin
      tests_failed++;
      $display("FAIL mid_reset_screen: got %0d cell diffs, want 0", screen_diffs());
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    test_reset();
    test_back_to_back();
    test_bs_tab();
    test_scroll_bottom();
    test_top_wrap();
    test_autowrap();
    test_random();
    test_reset_mid_clr_line();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
